// File: rtl/value_router_pipe.sv
// value_router_pipe: two-stage compare-and-route stage for the QuickQ priority queue.
// S1 registers the operand pair and the compare result; S2 registers the routed
// winner/loser and fb. Valid/ready on both sides, full throughput, bubbles collapse.
// Optional build macro: VALUE_ROUTER_STATS_EN adds swap_cnt / reg_win_cnt outputs.
module value_router_pipe #(
    parameter int KEY_W    = 16,
    parameter int VAL_W    = 16,
    parameter bit MIN_MODE = 1'b0,
    parameter bit SIGNED   = 1'b0,
    // Payload ports keep one bit when VAL_W = 0 (key-only entries, tied/unused)
    localparam int VW      = (VAL_W > 0) ? VAL_W : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] reg_key,
    input  logic [VW-1:0]    reg_val,
    input  logic [KEY_W-1:0] ram_key,
    input  logic [VW-1:0]    ram_val,
    input  logic             ram_empty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] win_key,
    output logic [VW-1:0]    win_val,
    output logic [KEY_W-1:0] lose_key,
    output logic [VW-1:0]    lose_val,
`ifdef VALUE_ROUTER_STATS_EN
    output logic [15:0]      swap_cnt,
    output logic [15:0]      reg_win_cnt,
`endif
    output logic             fb
);

    logic             s1_valid;
    logic             s1_ram_wins;
    logic [KEY_W-1:0] s1_reg_key;
    logic [VW-1:0]    s1_reg_val;
    logic [KEY_W-1:0] s1_ram_key;
    logic [VW-1:0]    s1_ram_val;
    logic             s2_ready;
    logic             ram_ge;
    logic             ram_le;
    logic             ram_wins;
    logic             s1_load;
    logic             s2_load;

    // Handshake: each stage can advance when the stage after it drains; flush blocks intake
    always_comb begin
        s2_ready  = !out_valid || out_ready;
        in_ready  = (!s1_valid || s2_ready) && !flush;
        s1_load   = in_valid && in_ready;
        s2_load   = s1_valid && s2_ready && !flush;
    end

    // Key compare; ties go to the BRAM entry so equal keys keep FIFO order
    always_comb begin
        if (SIGNED) begin
            ram_ge = $signed(ram_key) >= $signed(reg_key);
            ram_le = $signed(ram_key) <= $signed(reg_key);
        end else begin
            ram_ge = ram_key >= reg_key;
            ram_le = ram_key <= reg_key;
        end
        ram_wins = !ram_empty && (MIN_MODE ? ram_le : ram_ge);
    end

    // S1: capture operands and compare bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_ram_wins <= 1'b0;
            s1_reg_key  <= '0;
            s1_reg_val  <= '0;
            s1_ram_key  <= '0;
            s1_ram_val  <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (!s1_valid || s2_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_ram_wins <= ram_wins;
                s1_reg_key  <= reg_key;
                s1_reg_val  <= reg_val;
                s1_ram_key  <= ram_key;
                s1_ram_val  <= ram_val;
            end
        end
    end

    // S2: route winner/loser to the output registers, hold while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fb        <= 1'b0;
            win_key   <= '0;
            win_val   <= '0;
            lose_key  <= '0;
            lose_val  <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_ready) begin
                out_valid <= s1_valid;
            end
            if (s2_load) begin
                fb       <= s1_ram_wins;
                win_key  <= s1_ram_wins ? s1_ram_key : s1_reg_key;
                win_val  <= s1_ram_wins ? s1_ram_val : s1_reg_val;
                lose_key <= s1_ram_wins ? s1_reg_key : s1_ram_key;
                lose_val <= s1_ram_wins ? s1_reg_val : s1_ram_val;
            end
        end
    end

`ifdef VALUE_ROUTER_STATS_EN
    // Saturating per-winner counts of delivered results; flush clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_cnt    <= '0;
            reg_win_cnt <= '0;
        end else if (flush) begin
            swap_cnt    <= '0;
            reg_win_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (fb) begin
                if (swap_cnt != '1) swap_cnt <= swap_cnt + 16'd1;
            end else begin
                if (reg_win_cnt != '1) reg_win_cnt <= reg_win_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
